// File: rtl/cell_blank_picker.sv
// cell_blank_picker
// Draws random (row,col) pairs from the LFSR generator, rejects out-of-range or
// already-blanked cells, and emits one write strobe per Sudoku cell to blank.
// After MAX_REJECT consecutive rejects it takes the lowest unused cell instead,
// so every run finishes. An 81-bit mask records which cells are already blank.
// Optional feature: define SYMMETRIC_BLANK_EN to also blank the point-mirrored
// cell (8-r,8-c) after each pick, while the total still equals the target.
module cell_blank_picker #(
    parameter int SETTLE     = 2,
    parameter int MAX_REJECT = 255
) (
    input  logic       clka,
    input  logic       restart,
    input  logic       start,
    input  logic [6:0] num_blanks,
    input  logic [3:0] rand_A,
    input  logic [3:0] rand_B,
    output logic       gen_rand_flag,
    output logic       cell_we,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic       busy,
    output logic       done,
    output logic [7:0] fallbacks
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
`ifdef SYMMETRIC_BLANK_EN
    localparam logic [2:0] S_WRITE2 = 3'd7;
`endif

    localparam logic [6:0] CELLS       = 7'd81;
    localparam logic [6:0] CENTER_IDX  = 7'd40;
    localparam logic [6:0] LAST_IDX    = 7'd80;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE);
    localparam logic [7:0] REJECT_LIM  = 8'(MAX_REJECT);

    logic [2:0]  state;
    logic [7:0]  settle_cnt;
    logic [7:0]  rej_cnt;
    logic [80:0] mask;
    logic [6:0]  count;
    logic [6:0]  target;
    logic [3:0]  row_q;
    logic [3:0]  col_q;
    logic [7:0]  fb_q;

    logic [6:0]  draw_idx;
    logic        draw_in_range;
    logic        draw_ok;
    logic [6:0]  wr_idx;
    logic [6:0]  count_inc;
    logic        last_cell;
    logic [7:0]  rej_next;
    logic [3:0]  scan_row;
    logic [3:0]  scan_col;
    logic [6:0]  clamped_target;
`ifdef SYMMETRIC_BLANK_EN
    logic [6:0]  mir_idx;
    logic        mirror_go;
`endif

    // Linear board index 9*row+col, kept to 7 bits (max 80 for legal coords).
    function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        logic [6:0] r7;
        r7 = {3'b000, row};
        return (r7 << 3) + r7 + {3'b000, col};
    endfunction

    // Saturating increment for the fallback counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Requests above the board size are clamped to a full board.
    function automatic logic [6:0] clamp_target(input logic [6:0] n);
        return (n > CELLS) ? CELLS : n;
    endfunction

    assign draw_idx       = cell_index(rand_A, rand_B);
    assign draw_in_range  = (rand_A <= 4'd8) && (rand_B <= 4'd8);
    assign draw_ok        = draw_in_range && !mask[draw_idx];
    assign wr_idx         = cell_index(row_q, col_q);
    assign count_inc      = count + 7'd1;
    assign last_cell      = (count_inc == target);
    assign rej_next       = rej_cnt + 8'd1;
    assign clamped_target = clamp_target(num_blanks);
`ifdef SYMMETRIC_BLANK_EN
    assign mir_idx   = LAST_IDX - wr_idx;
    assign mirror_go = (wr_idx != CENTER_IDX) && !mask[mir_idx] && (count_inc < target);
`endif

    // Priority encoder over unused cells: the lowest free index wins.
    always_comb begin
        scan_row = 4'd0;
        scan_col = 4'd0;
        for (int r = 8; r >= 0; r--) begin
            for (int c = 8; c >= 0; c--) begin
                if (!mask[7'(r * 9 + c)]) begin
                    scan_row = 4'(r);
                    scan_col = 4'(c);
                end
            end
        end
    end

    // Main sequencer: request, settle, check/scan, write, repeat until target.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state      <= S_IDLE;
            settle_cnt <= 8'd0;
            rej_cnt    <= 8'd0;
            mask       <= '0;
            count      <= 7'd0;
            target     <= 7'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            fb_q       <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target  <= clamped_target;
                        mask    <= '0;
                        count   <= 7'd0;
                        rej_cnt <= 8'd0;
                        fb_q    <= 8'd0;
                        state   <= (clamped_target == 7'd0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt <= 8'd1) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (draw_ok) begin
                        row_q <= rand_A;
                        col_q <= rand_B;
                        state <= S_WRITE;
                    end else begin
                        rej_cnt <= rej_next;
                        state   <= (rej_next >= REJECT_LIM) ? S_SCAN : S_REQ;
                    end
                end
                S_SCAN: begin
                    row_q <= scan_row;
                    col_q <= scan_col;
                    fb_q  <= sat_inc8(fb_q);
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    mask[wr_idx] <= 1'b1;
                    count        <= count_inc;
                    rej_cnt      <= 8'd0;
`ifdef SYMMETRIC_BLANK_EN
                    if (mirror_go) begin
                        row_q <= 4'd8 - row_q;
                        col_q <= 4'd8 - col_q;
                        state <= S_WRITE2;
                    end else begin
                        state <= last_cell ? S_DONE : S_REQ;
                    end
`else
                    state <= last_cell ? S_DONE : S_REQ;
`endif
                end
`ifdef SYMMETRIC_BLANK_EN
                S_WRITE2: begin
                    mask[wr_idx] <= 1'b1;
                    count        <= count_inc;
                    state        <= last_cell ? S_DONE : S_REQ;
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign gen_rand_flag = (state == S_REQ);
`ifdef SYMMETRIC_BLANK_EN
    assign cell_we       = (state == S_WRITE) || (state == S_WRITE2);
`else
    assign cell_we       = (state == S_WRITE);
`endif
    assign cell_row      = row_q;
    assign cell_col      = col_q;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign fallbacks     = fb_q;

endmodule

// File: tb/tb_cell_blank_picker.sv
// tb_cell_blank_picker
// Table-driven directed runs, hand-written corner sequences (forced fallback,
// duplicates, mid-run restart) and randomized runs checked against a
// sequence-level model of the picking rules.
// Honours SYMMETRIC_BLANK_EN when the design is built with it.
module tb_cell_blank_picker;

    localparam int SETTLE     = 2;
    localparam int MAX_REJECT = 255;

    logic       clka = 1'b0;
    logic       restart = 1'b1;
    logic       start = 1'b0;
    logic [6:0] num_blanks = 7'd0;
    logic [3:0] rand_A = 4'd0;
    logic [3:0] rand_B = 4'd0;
    logic       gen_rand_flag;
    logic       cell_we;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic       busy;
    logic       done;
    logic [7:0] fallbacks;

    cell_blank_picker #(.SETTLE(SETTLE), .MAX_REJECT(MAX_REJECT)) dut (
        .clka(clka), .restart(restart), .start(start), .num_blanks(num_blanks),
        .rand_A(rand_A), .rand_B(rand_B), .gen_rand_flag(gen_rand_flag),
        .cell_we(cell_we), .cell_row(cell_row), .cell_col(cell_col),
        .busy(busy), .done(done), .fallbacks(fallbacks)
    );

    always #5 clka = ~clka;

    int total = 0;
    int bad = 0;

    // generator stub
    logic [3:0] stub_a[$];
    logic [3:0] stub_b[$];
    bit         stub_rand;
    logic [3:0] hold_a, hold_b;

    // run record
    int drawn_a[$], drawn_b[$];
    int wr_r[$], wr_c[$], wr_cyc[$];
    int req_cnt, first_req_cyc, done_cyc, busy_low;
    bit hit_restart;

    // model output
    int exp_r[$], exp_c[$];
    int exp_fb, exp_draws;

    typedef struct {
        int nb;
        int a0, b0, a1, b1;
        int exp_req;
        int exp_writes;
        int exp_row, exp_col;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int clamp81(input int n);
        return (n > 81) ? 81 : n;
    endfunction

    task automatic clear_stub();
        stub_a.delete();
        stub_b.delete();
        stub_rand = 0;
        hold_a = 4'd0;
        hold_b = 4'd0;
    endtask

    // Start a run and observe it cycle by cycle; cycle 1 is the one after the start edge.
    task automatic run(input int nb, input int max_cyc, input int restart_at);
        drawn_a.delete(); drawn_b.delete();
        wr_r.delete(); wr_c.delete(); wr_cyc.delete();
        req_cnt = 0; first_req_cyc = -1; done_cyc = -1; busy_low = 0; hit_restart = 0;
        @(negedge clka);
        num_blanks = 7'(nb);
        start = 1'b1;
        @(posedge clka);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clka);
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy) busy_low++;
            if (gen_rand_flag) begin
                req_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (stub_a.size() > 0) begin
                    rand_A = stub_a.pop_front();
                    rand_B = stub_b.pop_front();
                end else if (stub_rand) begin
                    rand_A = 4'($urandom_range(0, 10));
                    rand_B = 4'($urandom_range(0, 10));
                end else begin
                    rand_A = hold_a;
                    rand_B = hold_b;
                end
                drawn_a.push_back(int'(rand_A));
                drawn_b.push_back(int'(rand_B));
            end
            if (cell_we) begin
                wr_r.push_back(int'(cell_row));
                wr_c.push_back(int'(cell_col));
                wr_cyc.push_back(cyc);
                if (restart_at != 0 && wr_r.size() == restart_at) begin
                    restart = 1'b1;
                    hit_restart = 1;
                    break;
                end
            end
        end
        if (done_cyc < 0 && !hit_restart) check("run finished within budget", 0, 1);
    endtask

    // Replays the presented draws through the picking rules.
    task automatic model(input int nb);
        bit used[81];
        int target, n, d, rej, r, c;
        exp_r.delete(); exp_c.delete();
        exp_fb = 0;
        target = clamp81(nb);
        foreach (used[i]) used[i] = 0;
        n = 0; d = 0; rej = 0; r = 0; c = 0;
        while (n < target) begin
            if (rej == MAX_REJECT) begin
                for (int i = 0; i < 81; i++) begin
                    if (!used[i]) begin
                        r = i / 9;
                        c = i % 9;
                        break;
                    end
                end
                exp_fb++;
                rej = 0;
            end else begin
                if (d >= drawn_a.size()) break;
                r = drawn_a[d];
                c = drawn_b[d];
                d++;
                if (r > 8 || c > 8 || used[r * 9 + c]) begin
                    rej++;
                    continue;
                end
                rej = 0;
            end
            used[r * 9 + c] = 1;
            exp_r.push_back(r);
            exp_c.push_back(c);
            n++;
`ifdef SYMMETRIC_BLANK_EN
            if (n < target && !(r == 4 && c == 4) && !used[(8 - r) * 9 + (8 - c)]) begin
                used[(8 - r) * 9 + (8 - c)] = 1;
                exp_r.push_back(8 - r);
                exp_c.push_back(8 - c);
                n++;
            end
`endif
        end
        exp_draws = d;
    endtask

    task automatic compare_model(input string tag, input int nb);
        int n;
        model(nb);
        check($sformatf("%s write count", tag), wr_r.size(), clamp81(nb));
        n = (wr_r.size() < exp_r.size()) ? wr_r.size() : exp_r.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s write %0d row", tag, i), wr_r[i], exp_r[i]);
            check($sformatf("%s write %0d col", tag, i), wr_c[i], exp_c[i]);
        end
        check($sformatf("%s requests", tag), req_cnt, exp_draws);
        check($sformatf("%s fallbacks", tag), int'(fallbacks), (exp_fb > 255) ? 255 : exp_fb);
        check($sformatf("%s busy during run", tag), busy_low, 0);
    endtask

    // done must be a single-cycle pulse followed by IDLE.
    task automatic check_after_done(input string tag);
        @(negedge clka);
        check($sformatf("%s done one cycle", tag), int'(done), 0);
        check($sformatf("%s idle after done", tag), int'(busy), 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb_list[6];

        vecs[0] = '{1, 3, 5, 3, 5, 1, 1, 3, 5};
        vecs[1] = '{1, 12, 2, 2, 7, 2, 1, 2, 7};
        vecs[2] = '{1, 8, 8, 0, 0, 1, 1, 8, 8};
        vecs[3] = '{1, 9, 0, 0, 8, 2, 1, 0, 8};
        vecs[4] = '{1, 4, 15, 0, 0, 2, 1, 0, 0};
        vecs[5] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

        clear_stub();

        // Reset state
        repeat (2) @(posedge clka);
        @(negedge clka);
        check("reset gen_rand_flag", int'(gen_rand_flag), 0);
        check("reset cell_we", int'(cell_we), 0);
        check("reset cell_row", int'(cell_row), 0);
        check("reset cell_col", int'(cell_col), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset fallbacks", int'(fallbacks), 0);
        restart = 1'b0;
        repeat (2) @(negedge clka);

        // Directed single-cell runs
        for (int v = 0; v < 6; v++) begin
            clear_stub();
            stub_a.push_back(4'(vecs[v].a0)); stub_b.push_back(4'(vecs[v].b0));
            stub_a.push_back(4'(vecs[v].a1)); stub_b.push_back(4'(vecs[v].b1));
            hold_a = 4'(vecs[v].a1); hold_b = 4'(vecs[v].b1);
            run(vecs[v].nb, 300, 0);
            check($sformatf("vec%0d done seen", v), int'(done_cyc > 0), 1);
            check($sformatf("vec%0d requests", v), req_cnt, vecs[v].exp_req);
            check($sformatf("vec%0d writes", v), wr_r.size(), vecs[v].exp_writes);
            if (wr_r.size() > 0) begin
                check($sformatf("vec%0d row", v), wr_r[0], vecs[v].exp_row);
                check($sformatf("vec%0d col", v), wr_c[0], vecs[v].exp_col);
            end
            if (v == 0) begin
                check("first request cycle", first_req_cyc, 1);
                if (wr_cyc.size() > 0) check("first write cycle", wr_cyc[0], SETTLE + 3);
                check("single write done cycle", done_cyc, SETTLE + 4);
            end
            if (v == 5) check("zero blanks done cycle", done_cyc, 1);
            check_after_done($sformatf("vec%0d", v));
        end

        // Generator stuck at (0,0): forced fallback scan
        clear_stub();
        run(2, 3000, 0);
`ifdef SYMMETRIC_BLANK_EN
        check("stuck writes", wr_r.size(), 2);
        if (wr_r.size() == 2) begin
            check("stuck w0", wr_r[0] * 9 + wr_c[0], 0);
            check("stuck mirror", wr_r[1] * 9 + wr_c[1], 80);
        end
        check("stuck fallbacks", int'(fallbacks), 0);
        check("stuck requests", req_cnt, 1);
`else
        check("stuck writes", wr_r.size(), 2);
        if (wr_r.size() == 2) begin
            check("stuck w0", wr_r[0] * 9 + wr_c[0], 0);
            check("stuck scan pick", wr_r[1] * 9 + wr_c[1], 1);
        end
        check("stuck fallbacks", int'(fallbacks), 1);
        check("stuck requests", req_cnt, 1 + MAX_REJECT);
`endif
        check_after_done("stuck");

        // Duplicate draw and the board center
        clear_stub();
        stub_a = '{4'd1, 4'd4, 4'd1, 4'd8};
        stub_b = '{4'd2, 4'd4, 4'd2, 4'd0};
        run(3, 500, 0);
`ifdef SYMMETRIC_BLANK_EN
        check("sym writes", wr_r.size(), 3);
        if (wr_r.size() == 3) begin
            check("sym w0", wr_r[0] * 16 + wr_c[0], 1 * 16 + 2);
            check("sym w1 mirror", wr_r[1] * 16 + wr_c[1], 7 * 16 + 6);
            check("sym w2 center", wr_r[2] * 16 + wr_c[2], 4 * 16 + 4);
        end
        check("sym requests", req_cnt, 2);
`else
        check("dup writes", wr_r.size(), 3);
        if (wr_r.size() == 3) begin
            check("dup w0", wr_r[0] * 16 + wr_c[0], 1 * 16 + 2);
            check("dup w1", wr_r[1] * 16 + wr_c[1], 4 * 16 + 4);
            check("dup w2", wr_r[2] * 16 + wr_c[2], 8 * 16 + 0);
        end
        check("dup requests", req_cnt, 4);
`endif
        check_after_done("dup");

        // Randomized runs against the model, including full board and clamping
        nb_list[0] = 5;
        nb_list[1] = 30;
        nb_list[2] = 81;
        nb_list[3] = 127;
        nb_list[4] = $urandom_range(1, 100);
        nb_list[5] = $urandom_range(1, 40);
        for (int k = 0; k < 6; k++) begin
            clear_stub();
            stub_rand = 1;
            run(nb_list[k], 20000, 0);
            compare_model($sformatf("rand%0d(nb=%0d)", k, nb_list[k]), nb_list[k]);
            check_after_done($sformatf("rand%0d", k));
        end

        // Restart during the 20th write of a full-board run
        clear_stub();
        stub_rand = 1;
        run(81, 20000, 20);
        check("restart reached", int'(hit_restart), 1);
        @(negedge clka);
        check("restart gen_rand_flag", int'(gen_rand_flag), 0);
        check("restart cell_we", int'(cell_we), 0);
        check("restart cell_row", int'(cell_row), 0);
        check("restart cell_col", int'(cell_col), 0);
        check("restart busy", int'(busy), 0);
        check("restart done", int'(done), 0);
        check("restart fallbacks", int'(fallbacks), 0);
        restart = 1'b0;
        begin
            int done_seen;
            done_seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clka);
                if (done || busy) done_seen++;
            end
            check("no done or busy after restart", done_seen, 0);
        end
        clear_stub();
        stub_rand = 1;
        run(12, 20000, 0);
        compare_model("post-restart", 12);
        check_after_done("post-restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
